// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, FSM states and the result-buffer entry.
package alu_pkg;

  // Widest legal DATA_WIDTH; narrower instances zero-extend into the res field.
  localparam int ALU_MAX_WIDTH = 64;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic [ALU_MAX_WIDTH-1:0] res;
    logic                     carry;
    logic                     zero;
  } alu_res_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_res_fifo.sv
// Result buffer: FIFO of ALU results; outputs hold the last popped entry while empty.
module alu_res_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;

  assign valid  = (count != '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && valid;
  assign dout   = valid ? mem[rd_ptr] : last_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        last_q <= mem[rd_ptr];
      end
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU with single-cycle logic/arith/shift ops, a shift-add multiplier
// and a result FIFO carrying res, carry and zero.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RES_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  alu_op_t               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  carry,
  output logic                  zero,
  output logic                  busy
);

  localparam int SHW     = $clog2(DATA_WIDTH);
  localparam int ENTRY_W = DATA_WIDTH + 2;

  alu_state_t state;
  alu_state_t state_nxt;

  logic                    accept;
  logic                    push;
  logic                    mul_last;
  logic                    fifo_full;
  logic [SHW-1:0]          iter;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [2*DATA_WIDTH-1:0] mcand;
  logic [2*DATA_WIDTH-1:0] acc_step;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [SHW-1:0]          shamt;
  logic [DATA_WIDTH:0]     wide;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_carry;
  logic [DATA_WIDTH-1:0]   wr_res;
  logic                    wr_carry;
  alu_res_t                wr_ent;
  logic                    unused_res_hi;
  logic [ENTRY_W-1:0]      head;

  assign in_ready = !rst && (state == ST_IDLE) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ST_MUL);
  assign mul_last = busy && (iter == SHW'(DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && op == OP_MUL) state_nxt = ST_MUL;
      ST_MUL:  if (mul_last) state_nxt = ST_IDLE;
    endcase
  end

  // Shift-add: one multiplier bit per cycle, product completes on the last iteration.
  assign acc_step = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      iter   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (accept && op == OP_MUL) begin
      iter   <= '0;
      acc    <= '0;
      mcand  <= {{DATA_WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      iter   <= iter + SHW'(1);
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign shamt = b[SHW-1:0];

  // The extra bit of 'wide' catches carry-out, borrow, or the last bit shifted out.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    wide      = '0;
    case (op)
      OP_ADD: begin
        wide      = {1'b0, a} + {1'b0, b};
        alu_res   = wide[DATA_WIDTH-1:0];
        alu_carry = wide[DATA_WIDTH];
      end
      OP_SUB: begin
        wide      = {1'b0, a} - {1'b0, b};
        alu_res   = wide[DATA_WIDTH-1:0];
        alu_carry = wide[DATA_WIDTH];
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        wide      = {1'b0, a} << shamt;
        alu_res   = wide[DATA_WIDTH-1:0];
        alu_carry = wide[DATA_WIDTH];
      end
      OP_SHR: begin
        wide      = {a, 1'b0} >> shamt;
        alu_res   = wide[DATA_WIDTH:1];
        alu_carry = wide[0];
      end
      default: ;
    endcase
  end

  assign push     = (accept && op != OP_MUL) || mul_last;
  assign wr_res   = busy ? acc_step[DATA_WIDTH-1:0] : alu_res;
  assign wr_carry = busy ? |acc_step[2*DATA_WIDTH-1:DATA_WIDTH] : alu_carry;

  assign wr_ent = '{res:   ALU_MAX_WIDTH'(wr_res),
                    carry: wr_carry,
                    zero:  (wr_res == '0)};

  // Bits above DATA_WIDTH are the zero extension and never stored.
  assign unused_res_hi = |wr_ent.res;

  alu_res_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({wr_ent.res[DATA_WIDTH-1:0], wr_ent.carry, wr_ent.zero}),
    .pop   (out_ready),
    .dout  (head),
    .valid (out_valid),
    .full  (fifo_full)
  );

  assign res   = head[ENTRY_W-1:2];
  assign carry = head[1];
  assign zero  = head[0];

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus random traffic,
// all compared cycle by cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  alu_op_t       op;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] res;
  logic          carry;
  logic          zero;
  logic          busy;

  alu_pipe #(
    .DATA_WIDTH (DW),
    .RES_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .carry     (carry),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned r;
    bit          c;
    bit          z;
  } exp_t;

  exp_t q[$];
  exp_t shown;
  exp_t mul_exp;
  int   mul_left;
  int   cyc;
  int   n_checks;
  int   n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic exp_t ref_op(input alu_op_t o, input int unsigned x, input int unsigned y);
    int unsigned r;
    int unsigned sh;
    bit          c;
    r  = 0;
    c  = 1'b0;
    sh = y % DW;
    case (o)
      OP_ADD: begin r = x + y; c = (r > MASK); end
      OP_SUB: begin r = x - y; c = (x < y); end
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_SHL: begin r = x << sh; c = (sh != 0) && (((x >> (DW - sh)) & 1) != 0); end
      OP_SHR: begin r = x >> sh; c = (sh != 0) && (((x >> (sh - 1)) & 1) != 0); end
      OP_MUL: begin r = x * y; c = (r > MASK); end
    endcase
    r = r & MASK;
    return '{r, c, (r == 0)};
  endfunction

  function automatic bit model_ready();
    return !rst && (mul_left == 0) && (q.size() < DEPTH);
  endfunction

  task automatic check_outputs();
    exp_t h;
    h = (q.size() > 0) ? q[0] : shown;
    check("in_ready",  64'(in_ready),  64'(model_ready()));
    check("busy",      64'(busy),      64'(mul_left > 0));
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("res",       64'(res),       64'(h.r));
    check("carry",     64'(carry),     64'(h.c));
    check("zero",      64'(zero),      64'(h.z));
  endtask

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_edge();
    bit do_pop;
    bit do_acc;
    if (rst) begin
      q.delete();
      mul_left = 0;
      shown    = '{0, 1'b0, 1'b0};
      return;
    end
    do_pop = (q.size() > 0) && out_ready;
    do_acc = in_valid && model_ready();
    if (do_pop) shown = q.pop_front();
    if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) q.push_back(mul_exp);
    end
    if (do_acc) begin
      if (op == OP_MUL) begin
        mul_left = DW;
        mul_exp  = ref_op(op, a, b);
      end else begin
        q.push_back(ref_op(op, a, b));
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input bit v, input alu_op_t o, input logic [DW-1:0] x, input logic [DW-1:0] y);
    in_valid = v;
    op       = o;
    a        = x;
    b        = y;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    mul_left  = 0;
    shown     = '{0, 1'b0, 1'b0};
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, OP_ADD, '0, '0);
    @(negedge clk);

    // Reset state
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(in_ready), 64'd1);

    // ADD wrap-around: 0xFF + 0x01
    out_ready = 1'b1;
    drive(1'b1, OP_ADD, 8'hFF, 8'h01);
    cycle();
    in_valid = 1'b0;
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_res",   64'(res),       64'h00);
    check("add_carry", 64'(carry),     64'd1);
    check("add_zero",  64'(zero),      64'd1);
    cycle();

    // MUL 0x10 * 0x11 = 0x110
    drive(1'b1, OP_MUL, 8'h10, 8'h11);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < DW; i++) begin
      check("mul_busy",     64'(busy),      64'd1);
      check("mul_noready",  64'(in_ready),  64'd0);
      check("mul_novalid",  64'(out_valid), 64'd0);
      cycle();
    end
    check("mul_valid", 64'(out_valid), 64'd1);
    check("mul_busy0", 64'(busy),      64'd0);
    check("mul_res",   64'(res),       64'h10);
    check("mul_carry", 64'(carry),     64'd1);
    cycle();

    // Fill the buffer with four XORs, then release one entry
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, OP_XOR, 8'(8'h11 * (i + 1)), 8'h0F);
      cycle();
    end
    in_valid = 1'b0;
    check("full_noready", 64'(in_ready), 64'd0);
    check("fifo_head",    64'(res),      64'h1E);
    cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("ready_after_pop", 64'(in_ready), 64'd1);
    check("fifo_second",     64'(res),      64'h2D);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) cycle();

    // Shifts
    drive(1'b1, OP_SHL, 8'h81, 8'h09);
    cycle();
    check("shl_res",   64'(res),   64'h02);
    check("shl_carry", 64'(carry), 64'd1);
    drive(1'b1, OP_SHR, 8'h81, 8'h00);
    cycle();
    in_valid = 1'b0;
    check("shr_res",   64'(res),   64'h81);
    check("shr_carry", 64'(carry), 64'd0);
    cycle();

    // Reset three cycles into a multiply, then SUB with borrow
    drive(1'b1, OP_MUL, 8'hA5, 8'h3C);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b1;
    cycle();
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready),  64'd0);
    rst = 1'b0;
    drive(1'b1, OP_SUB, 8'h03, 8'h05);
    cycle();
    in_valid = 1'b0;
    check("sub_valid", 64'(out_valid), 64'd1);
    check("sub_res",   64'(res),       64'hFE);
    check("sub_carry", 64'(carry),     64'd1);
    check("sub_zero",  64'(zero),      64'd0);
    cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = ($urandom_range(0, 7) == 0) ? OP_MUL : alu_op_t'(3'($urandom_range(0, 6)));
      case ($urandom_range(0, 5))
        0:       a = 8'h00;
        1:       a = 8'hFF;
        default: a = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       b = 8'h00;
        1:       b = 8'hFF;
        default: b = 8'($urandom);
      endcase
      cycle();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DW + DEPTH + 2; i++) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
